alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (ctrl codes: and 000, or 001, add 010, mul 011, sub 110, slt 111)
//  between two requesters, e.g. EX stage and address unit. Round-robin grant, valid/ready request
//  handshake, multi-cycle hold for mul, one registered response port tagged with requester id.
//  Sits between requesters and the ALU instance; owns the ALU operand/ctrl inputs.
// PARAMETERS
//  WIDTH       32  operand/result width
//  MUL_CYCLES  3   cycles operands are held on ALU for mul (>=1); all other ops hold 1 cycle
//  CNT_W       16  grant counter width (used only with ALU_ARB_STATS_EN)
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      reset, synchronous, active-high
//  reqN_valid_i   in   1      N=0,1: request present
//  reqN_ready_o   out  1      N=0,1: request accepted this cycle when valid&ready
//  reqN_ctrl_i    in   3      N=0,1: ALU ctrl code
//  reqN_data1_i   in   WIDTH  N=0,1: operand 1
//  reqN_data2_i   in   WIDTH  N=0,1: operand 2
//  resp_valid_o   out  1      result available
//  resp_ready_i   in   1      consumer takes result when valid&ready
//  resp_id_o      out  1      requester index of result
//  resp_data_o    out  WIDTH  result
//  resp_zero_o    out  1      result == 0
//  alu_data1_o    out  WIDTH  to ALU operand 1
//  alu_data2_o    out  WIDTH  to ALU operand 2
//  alu_ctrl_o     out  3      to ALU ctrl
//  alu_data_i     in   WIDTH  from ALU result
//  alu_zero_i     in   1      from ALU zero flag
// BEHAVIOUR
//  - FSM IDLE -> EXEC -> RESP -> IDLE. Reset: state IDLE, rr pointer "last=1" (req0 wins first),
//    all registered outputs 0, alu_*_o 0 (ctrl 000); in-flight op and pending response dropped.
//  - IDLE: grant = only valid requester, or if both valid the one != last. reqN_ready_o=1 only for
//    granted N in IDLE (combinational from state+valids); 0 in EXEC/RESP. On transfer latch
//    ctrl/operands/id, update last=id, cycle counter = (ctrl==011 ? MUL_CYCLES : 1), go EXEC.
//  - EXEC: alu_*_o driven from latched regs (registered, stable whole phase). Counter decrements;
//    on final EXEC cycle capture alu_data_i/alu_zero_i into resp regs, go RESP.
//  - Latency: accept at edge N -> resp_valid_o high from edge N+L+1, L = hold cycles (1 or MUL_CYCLES).
//  - RESP: resp_valid_o=1, data/zero/id stable until resp_ready_i; on handshake -> IDLE, valid=0.
//    No new accept in same cycle as response handshake (one-cycle bubble in IDLE is required).
//  - Unsupported ctrl 100/101: accepted normally, EXEC 1 cycle, ALU not sampled; response data 0, zero 1.
//  - Requester may drop valid before ready without penalty; a request held while other is served
//    is granted next (starvation-free: max wait = one full transaction).
//  - alu_*_o return to 0/000 in IDLE and RESP.
//  - Arithmetic: no width change; mul result is low WIDTH bits as returned by ALU.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: extra outputs grant0_cnt_o, grant1_cnt_o [CNT_W-1:0], +1 per accepted
//  request of that requester, saturate at all-ones, cleared by rst_i.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package alu_arb_pkg: ALU ctrl code localparams (OP_AND..OP_SLT), FSM state enum (2-bit), WIDTH default.
//  Sub-module alu_rr_pick: 2-way round-robin picker (valids, last -> grant one-hot, id). FSM,
//  latch regs, hold counter, response regs stay in top.
// TESTING
//  1 req0 add 5+7, resp_ready=1 -> ready0 1 cycle, resp at accept+2: id0 data 12 zero0.
//  2 req1 mul 6*7, MUL_CYCLES=3 -> alu_ctrl_o 011 held 3 cycles, resp data 42 at accept+4.
//  3 both valid from reset: req0 sub 9-9, req1 slt 3<4 -> req0 first (data 0 zero 1), then req1 (data 1).
//  4 resp_ready=0 for 5 cycles -> resp_valid/data stable, both reqN_ready_o stay 0, then drains.
//  5 rst_i asserted mid-mul (EXEC cycle 2) -> next cycle IDLE, no resp_valid, alu_ctrl_o 000.
//  6 ctrl 100 from req1 -> resp data 0 zero 1 at accept+2; with ALU_ARB_STATS_EN grant1_cnt_o=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes, FSM state encoding, defaults.
// Optional statistics counters are enabled with the ALU_ARB_STATS_EN macro.
package alu_arb_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Codes 100/101 have no ALU meaning; they complete with a forced zero result.
  function automatic logic op_supported(input logic [2:0] ctrl);
    return !((ctrl == 3'b100) || (ctrl == 3'b101));
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: a lone valid requester wins, a tie goes to the one not served last.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       id
);

  always_comb begin
    grant = 2'b00;
    id    = 1'b0;
    case (valid)
      2'b01: begin
        grant = 2'b01;
        id    = 1'b0;
      end
      2'b10: begin
        grant = 2'b10;
        id    = 1'b1;
      end
      2'b11: begin
        if (last) begin
          grant = 2'b01;
          id    = 1'b0;
        end else begin
          grant = 2'b10;
          id    = 1'b1;
        end
      end
      default: begin
        grant = 2'b00;
        id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant and a tagged response.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_ctrl_i,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_ctrl_i,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             resp_zero_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0] grant0_cnt_o,
  output logic [CNT_W-1:0] grant1_cnt_o,
`endif
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request transfers on a rising edge where reqN_valid_i and reqN_ready_o are both 1;
  // the response transfers where resp_valid_o and resp_ready_i are both 1. Valid may drop freely.

  localparam int HOLD_W = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MUL = HOLD_W'(MUL_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t        state;
  logic              last;
  logic [1:0]        grant;
  logic              pick_id;
  logic              accept;
  logic [2:0]        sel_ctrl;
  logic [WIDTH-1:0]  sel_data1;
  logic [WIDTH-1:0]  sel_data2;
  logic [2:0]        op_ctrl;
  logic [WIDTH-1:0]  op_data1;
  logic [WIDTH-1:0]  op_data2;
  logic              op_id;
  logic [HOLD_W-1:0] hold_cnt;

  alu_rr_pick u_pick (
    .valid ({req1_valid_i, req0_valid_i}),
    .last  (last),
    .grant (grant),
    .id    (pick_id)
  );

  assign req0_ready_o = (state == ST_IDLE) && grant[0];
  assign req1_ready_o = (state == ST_IDLE) && grant[1];
  assign accept       = (state == ST_IDLE) && (grant != 2'b00);
  assign dbg_state_o  = state;

  assign sel_ctrl  = pick_id ? req1_ctrl_i  : req0_ctrl_i;
  assign sel_data1 = pick_id ? req1_data1_i : req0_data1_i;
  assign sel_data2 = pick_id ? req1_data2_i : req0_data2_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      last         <= 1'b1;
      op_ctrl      <= 3'b000;
      op_data1     <= '0;
      op_data2     <= '0;
      op_id        <= 1'b0;
      hold_cnt     <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= 1'b0;
      resp_data_o  <= '0;
      resp_zero_o  <= 1'b0;
      alu_data1_o  <= '0;
      alu_data2_o  <= '0;
      alu_ctrl_o   <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_ctrl  <= sel_ctrl;
            op_data1 <= sel_data1;
            op_data2 <= sel_data2;
            op_id    <= pick_id;
            last     <= pick_id;
            hold_cnt <= (sel_ctrl == OP_MUL) ? HOLD_MUL : HOLD_ONE;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Operands sit on the ALU for hold_cnt cycles, then the settled result is captured.
          if (hold_cnt != '0) begin
            alu_data1_o <= op_data1;
            alu_data2_o <= op_data2;
            alu_ctrl_o  <= op_ctrl;
            hold_cnt    <= hold_cnt - HOLD_ONE;
          end else begin
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_ctrl_o   <= 3'b000;
            resp_valid_o <= 1'b1;
            resp_id_o    <= op_id;
            if (op_supported(op_ctrl)) begin
              resp_data_o <= alu_data_i;
              resp_zero_o <= alu_zero_i;
            end else begin
              resp_data_o <= '0;
              resp_zero_o <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant0_cnt_o <= '0;
      grant1_cnt_o <= '0;
    end else begin
      if (req0_valid_i && req0_ready_o && (grant0_cnt_o != '1)) begin
        grant0_cnt_o <= grant0_cnt_o + 1'b1;
      end
      if (req1_valid_i && req1_ready_o && (grant1_cnt_o != '1)) begin
        grant1_cnt_o <= grant1_cnt_o + 1'b1;
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^(32'(CNT_W));
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to its alu_* ports.
// Build with ALU_ARB_STATS_EN to also check the grant counters.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [2:0]   req0_ctrl;
  logic [W-1:0] req0_data1, req0_data2;
  logic         req1_valid, req1_ready;
  logic [2:0]   req1_ctrl;
  logic [W-1:0] req1_data1, req1_data2;
  logic         resp_valid, resp_ready, resp_id, resp_zero;
  logic [W-1:0] resp_data;
  logic [W-1:0] alu_data1, alu_data2, alu_data;
  logic [2:0]   alu_ctrl;
  logic         alu_zero;
  logic [1:0]   dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant0_cnt, grant1_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_share_arbiter #(.WIDTH(W), .MUL_CYCLES(3), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_ctrl_i  (req0_ctrl),
    .req0_data1_i (req0_data1),
    .req0_data2_i (req0_data2),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_ctrl_i  (req1_ctrl),
    .req1_data1_i (req1_data1),
    .req1_data2_i (req1_data2),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_data_o  (resp_data),
    .resp_zero_o  (resp_zero),
    .alu_data1_o  (alu_data1),
    .alu_data2_o  (alu_data2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_data),
    .alu_zero_i   (alu_zero),
`ifdef ALU_ARB_STATS_EN
    .grant0_cnt_o (grant0_cnt),
    .grant1_cnt_o (grant1_cnt),
`endif
    .dbg_state_o  (dbg_state)
  );

  // The shared ALU; unsupported codes return a junk pattern that must never reach the response.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_data = alu_data1 & alu_data2;
      3'b001:  alu_data = alu_data1 | alu_data2;
      3'b010:  alu_data = alu_data1 + alu_data2;
      3'b011:  alu_data = alu_data1 * alu_data2;
      3'b110:  alu_data = alu_data1 - alu_data2;
      3'b111:  alu_data = {31'b0, ($signed(alu_data1) < $signed(alu_data2))};
      default: alu_data = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_data == '0);

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic [2:0] ctrl, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    if (n == 0) begin
      req0_valid = 1'b1; req0_ctrl = ctrl; req0_data1 = a; req0_data2 = b;
    end else begin
      req1_valid = 1'b1; req1_ctrl = ctrl; req1_data1 = a; req1_data2 = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_ctrl = 3'b000; req0_data1 = '0; req0_data2 = '0;
    req1_valid = 1'b0; req1_ctrl = 3'b000; req1_data1 = '0; req1_data2 = '0;
    do_reset();

    // reset state
    check("rst_state", dbg_state, 2'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_alu_ctrl", alu_ctrl, 3'b000);
    check("rst_alu_data1", alu_data1, 32'd0);

    // 1: req0 add 5+7
    drive_req(0, 3'b010, 32'd5, 32'd7);
    #1;
    check("t1_ready0", req0_ready, 1'b1);
    check("t1_ready1", req1_ready, 1'b0);
    next_cycle();
    req0_valid = 1'b0;
    check("t1_ready0_exec", req0_ready, 1'b0);
    check("t1_state_exec", dbg_state, 2'd1);
    check("t1_no_resp_n1", resp_valid, 1'b0);
    next_cycle();
    check("t1_alu_ctrl", alu_ctrl, 3'b010);
    check("t1_alu_d1", alu_data1, 32'd5);
    check("t1_alu_d2", alu_data2, 32'd7);
    check("t1_no_resp_n2", resp_valid, 1'b0);
    next_cycle();
    check("t1_resp_valid", resp_valid, 1'b1);
    check("t1_resp_id", resp_id, 1'b0);
    check("t1_resp_data", resp_data, 32'd12);
    check("t1_resp_zero", resp_zero, 1'b0);
    check("t1_alu_idle", alu_ctrl, 3'b000);
    next_cycle();
    check("t1_drained", resp_valid, 1'b0);
    check("t1_idle", dbg_state, 2'd0);

    // 2: req1 mul 6*7 holds the ALU for three cycles
    drive_req(1, 3'b011, 32'd6, 32'd7);
    #1;
    check("t2_ready1", req1_ready, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    check("t2_alu_pre", alu_ctrl, 3'b000);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check($sformatf("t2_alu_mul_c%0d", i), alu_ctrl, 3'b011);
      check($sformatf("t2_no_resp_c%0d", i), resp_valid, 1'b0);
    end
    next_cycle();
    check("t2_resp_valid", resp_valid, 1'b1);
    check("t2_resp_id", resp_id, 1'b1);
    check("t2_resp_data", resp_data, 32'd42);
    check("t2_alu_released", alu_ctrl, 3'b000);
    next_cycle();
    check("t2_idle", dbg_state, 2'd0);

    // 3: both valid from reset, req0 wins, req1 next
    do_reset();
    drive_req(0, 3'b110, 32'd9, 32'd9);
    drive_req(1, 3'b111, 32'd3, 32'd4);
    #1;
    check("t3_ready0", req0_ready, 1'b1);
    check("t3_ready1", req1_ready, 1'b0);
    next_cycle();
    req0_valid = 1'b0;
    check("t3_ready1_exec", req1_ready, 1'b0);
    next_cycle();
    next_cycle();
    check("t3_resp0_valid", resp_valid, 1'b1);
    check("t3_resp0_id", resp_id, 1'b0);
    check("t3_resp0_data", resp_data, 32'd0);
    check("t3_resp0_zero", resp_zero, 1'b1);
    check("t3_ready1_resp", req1_ready, 1'b0);
    next_cycle();
    check("t3_bubble_valid", resp_valid, 1'b0);
    check("t3_ready1_idle", req1_ready, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("t3_resp1_valid", resp_valid, 1'b1);
    check("t3_resp1_id", resp_id, 1'b1);
    check("t3_resp1_data", resp_data, 32'd1);
    check("t3_resp1_zero", resp_zero, 1'b0);
    next_cycle();

    // 4: response backpressure, waiting req1 served next
    resp_ready = 1'b0;
    drive_req(0, 3'b000, 32'd5, 32'd3);
    drive_req(1, 3'b001, 32'd1, 32'd2);
    #1;
    check("t4_ready0", req0_ready, 1'b1);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold_valid_%0d", i), resp_valid, 1'b1);
      check($sformatf("t4_hold_data_%0d", i), resp_data, 32'd1);
      check($sformatf("t4_hold_id_%0d", i), resp_id, 1'b0);
      check($sformatf("t4_hold_rdy_%0d", i), {req1_ready, req0_ready}, 2'b00);
      next_cycle();
    end
    resp_ready = 1'b1;
    #1;
    check("t4_rdy1_resp", req1_ready, 1'b0);
    next_cycle();
    check("t4_drained", resp_valid, 1'b0);
    check("t4_rdy1_idle", req1_ready, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("t4_resp1_id", resp_id, 1'b1);
    check("t4_resp1_data", resp_data, 32'd3);
    next_cycle();

    // 5: reset during the second mul EXEC cycle
    drive_req(0, 3'b011, 32'd3, 32'd4);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    check("t5_alu_mul", alu_ctrl, 3'b011);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("t5_state", dbg_state, 2'd0);
    check("t5_resp_valid", resp_valid, 1'b0);
    check("t5_alu_ctrl", alu_ctrl, 3'b000);
    next_cycle();
    next_cycle();
    next_cycle();
    check("t5_no_late_resp", resp_valid, 1'b0);

    // 6: unsupported ctrl 100 from req1
    drive_req(1, 3'b100, 32'd5, 32'd5);
    #1;
    check("t6_ready1", req1_ready, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    check("t6_no_resp", resp_valid, 1'b0);
    next_cycle();
    check("t6_resp_valid", resp_valid, 1'b1);
    check("t6_resp_id", resp_id, 1'b1);
    check("t6_resp_data", resp_data, 32'd0);
    check("t6_resp_zero", resp_zero, 1'b1);
`ifdef ALU_ARB_STATS_EN
    check("t6_grant1_cnt", grant1_cnt, 16'd1);
    check("t6_grant0_cnt", grant0_cnt, 16'd0);
`endif
    next_cycle();
    check("t6_idle", dbg_state, 2'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
